// File: rtl/ps2_keyboard_event_controller.sv
// PS/2 keyboard receiver that folds E0/F0 prefixes into {ext, brk, scancode} events and buffers
// them in a FIFO. Define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeated make events.
module ps2_keyboard_event_controller #(
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter int unsigned SYNC_STAGES     = 3,
  parameter int unsigned TIMEOUT_CYCLES  = 50000
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       nextdata_n,
  output logic [9:0]                 data,
  output logic                       ready,
  output logic                       overflow,
  output logic                       frame_error,
  output logic [FIFO_DEPTH_LOG2:0]   count
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned ToW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] CntFull = (FIFO_DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

  // Synchronisers reset high so the idle bus never looks like a falling edge.
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                   clk_prev_q;
  logic                   fall, bit_in;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in = data_sync_q[SYNC_STAGES-1];

  state_e           state_q, state_d;
  logic [3:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [ToW-1:0]   idle_cnt_q;
  logic             timeout, frame_ok, abort;

  assign timeout = (state_q != StIdle) && !fall && (idle_cnt_q == ToLast);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = StIdle;
    end else if (fall) begin
      unique case (state_q)
        StIdle:   if (!bit_in) state_d = StData;
        StData:   if (bit_cnt_q == 4'd7) state_d = StParity;
        StParity: state_d = StStop;
        StStop:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    frame_ok    = 1'b0;
    frame_error = 1'b0;
    abort       = 1'b0;
    if (timeout) begin
      frame_error = 1'b1;
      abort       = 1'b1;
    end else if (fall) begin
      case (state_q)
        StIdle: frame_error = bit_in;
        StStop: begin
          frame_ok    = bit_in & (^shift_q ^ parity_q);
          frame_error = ~frame_ok;
          abort       = ~frame_ok;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      if (state_q == StIdle || fall) idle_cnt_q <= '0;
      else                           idle_cnt_q <= idle_cnt_q + 1'b1;
      if (fall) begin
        case (state_q)
          StIdle: bit_cnt_q <= '0;
          StData: begin
            shift_q   <= {bit_in, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
          end
          StParity: parity_q <= bit_in;
          default: ;
        endcase
      end
    end
  end

  // Prefix decoder.
  logic       ext_q, brk_q, emit, push_req;
  logic [9:0] ev;

  assign emit = frame_ok && (shift_q != 8'hE0) && (shift_q != 8'hF0);
  assign ev   = {ext_q, brk_q, shift_q};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (abort) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (frame_ok) begin
      if (shift_q == 8'hE0)      ext_q <= 1'b1;
      else if (shift_q == 8'hF0) brk_q <= 1'b1;
      else begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic       held_q;
  logic [8:0] held_key_q;
  logic       key_match;

  assign key_match = held_q && (held_key_q == {ext_q, shift_q});
  assign push_req  = emit && !(!brk_q && key_match);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      held_q     <= 1'b0;
      held_key_q <= '0;
    end else if (emit) begin
      if (brk_q) begin
        if (key_match) held_q <= 1'b0;
      end else if (!key_match) begin
        held_key_q <= {ext_q, shift_q};
        held_q     <= 1'b1;
      end
    end
  end
`else
  assign push_req = emit;
`endif

  // Event FIFO.
  logic [9:0]                 mem [Depth];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       overflow_q, full, pop, push_ok;

  assign full    = (count_q == CntFull);
  assign ready   = (count_q != '0);
  assign pop     = ready & ~nextdata_n;
  assign push_ok = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= ev;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_q <= count_q + 1'b1;
      else if (!push_ok && pop) count_q <= count_q - 1'b1;
      if (push_req && full && !pop) overflow_q <= 1'b1;
    end
  end

  assign data     = ready ? mem[rd_ptr_q] : 10'h000;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule
